ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard over the

---
 rtl/ps2_host_tx.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, device-clocked frame, ACK check.
// Optional feature macro PS2_TX_RETRY_EN: NACK / transfer timeout are retried up to twice.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES       = 12000,
    parameter int unsigned START_TIMEOUT_CYCLES = 1500000,
    parameter int unsigned XFER_TIMEOUT_CYCLES  = 200000,
    parameter int unsigned FILTER_LEN           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       rx_inhibit,
    output logic       tx_done,
    output logic       tx_error,
    output logic [1:0] err_code,
    output logic [2:0] dbg_state
);
    localparam int unsigned TO_MAX = (START_TIMEOUT_CYCLES > XFER_TIMEOUT_CYCLES) ?
                                     START_TIMEOUT_CYCLES : XFER_TIMEOUT_CYCLES;
    localparam int TO_W  = $clog2(TO_MAX + 1);
    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    localparam logic [TO_W-1:0]  START_LIMIT = TO_W'(START_TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]  XFER_LIMIT  = TO_W'(XFER_TIMEOUT_CYCLES);
    localparam logic [INH_W-1:0] INH_LAST    = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [FLT_W-1:0] FLT_LAST    = FLT_W'(FILTER_LEN - 1);

    localparam logic [1:0] ERR_NACK  = 2'b01;
    localparam logic [1:0] ERR_START = 2'b10;
    localparam logic [1:0] ERR_XFER  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_REQ       = 3'd2,
        S_DATA      = 3'd3,
        S_ACK       = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Pin conditioning: 2-flop synchronizers, PS2Clk level filter, fall strobe
    // ------------------------------------------------------------------
    logic                 clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic                 data_s1_q, data_s1_d, data_s2_q, data_s2_d;
    logic                 clk_filt_q, clk_filt_d;
    logic [FLT_W-1:0]     filt_cnt_q, filt_cnt_d;
    logic                 fall_q, fall_d;

    always_comb begin
        clk_s1_d   = ps2_clk_in;
        clk_s2_d   = clk_s1_q;
        data_s1_d  = ps2_data_in;
        data_s2_d  = data_s1_q;
        clk_filt_d = clk_filt_q;
        filt_cnt_d = '0;
        // The filtered level only moves after FILTER_LEN consecutive disagreeing samples.
        if (clk_s2_q != clk_filt_q) begin
            if (filt_cnt_q == FLT_LAST) begin
                clk_filt_d = clk_s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
        fall_d = clk_filt_q & ~clk_filt_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            data_s1_q  <= 1'b1;
            data_s2_q  <= 1'b1;
            clk_filt_q <= 1'b1;
            filt_cnt_q <= '0;
            fall_q     <= 1'b0;
        end else begin
            clk_s1_q   <= clk_s1_d;
            clk_s2_q   <= clk_s2_d;
            data_s1_q  <= data_s1_d;
            data_s2_q  <= data_s2_d;
            clk_filt_q <= clk_filt_d;
            filt_cnt_q <= filt_cnt_d;
            fall_q     <= fall_d;
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // Handshake: a byte is accepted on a cycle where tx_valid && tx_ready; tx_ready is
    // high only in IDLE, and tx_valid outside IDLE is ignored, never queued.
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [INH_W-1:0]  inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic              data_oe_q, data_oe_d;
    logic [7:0]        byte_q, byte_d;
    logic              parity_q, parity_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [9:0]        frame;
    logic              done_c, error_c, fail_nack, fail_xfer;
    logic [1:0]        err_new;
`ifdef PS2_TX_RETRY_EN
    logic [1:0]        retry_cnt_q, retry_cnt_d;
`endif

    // Frame order on the wire after the start bit: data LSB first, parity, stop.
    assign frame = {1'b1, parity_q, byte_q};

    always_comb begin
        state_d    = state_q;
        inh_cnt_d  = inh_cnt_q;
        to_cnt_d   = to_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        data_oe_d  = data_oe_q;
        byte_d     = byte_q;
        parity_d   = parity_q;
        err_code_d = err_code_q;
        done_c     = 1'b0;
        error_c    = 1'b0;
        fail_nack  = 1'b0;
        fail_xfer  = 1'b0;
        err_new    = 2'b00;
`ifdef PS2_TX_RETRY_EN
        retry_cnt_d = retry_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                inh_cnt_d = '0;
                to_cnt_d  = '0;
                bit_cnt_d = '0;
                data_oe_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
                retry_cnt_d = '0;
`endif
                if (tx_valid) begin
                    byte_d   = tx_data;
                    parity_d = ~^tx_data;
                    state_d  = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                if (inh_cnt_q == INH_LAST) begin
                    inh_cnt_d = '0;
                    to_cnt_d  = '0;
                    state_d   = S_REQ;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end

            S_REQ: begin
                // Timeout is checked before the fall so it wins a same-cycle tie.
                if (to_cnt_q == START_LIMIT) begin
                    error_c = 1'b1;
                    err_new = ERR_START;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (fall_q) begin
                        // The device's first falling edge already asks for data bit 0.
                        data_oe_d = ~frame[0];
                        bit_cnt_d = 4'd1;
                        to_cnt_d  = '0;
                        state_d   = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (to_cnt_q == XFER_LIMIT) begin
                    fail_xfer = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (fall_q) begin
                        data_oe_d = ~frame[bit_cnt_q];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 4'd9) begin
                            state_d = S_ACK;
                        end
                    end
                end
            end

            S_ACK: begin
                data_oe_d = 1'b0;
                if (to_cnt_q == XFER_LIMIT) begin
                    fail_xfer = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (fall_q) begin
                        if (!data_s2_q) begin
                            state_d = S_WAIT_IDLE;
                        end else begin
                            fail_nack = 1'b1;
                        end
                    end
                end
            end

            S_WAIT_IDLE: begin
                if (to_cnt_q == XFER_LIMIT) begin
                    fail_xfer = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (clk_filt_q && data_s2_q) begin
                        done_c  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        if (fail_nack || fail_xfer) begin
`ifdef PS2_TX_RETRY_EN
            if (retry_cnt_q != 2'd2) begin
                retry_cnt_d = retry_cnt_q + 1'b1;
                inh_cnt_d   = '0;
                to_cnt_d    = '0;
                bit_cnt_d   = '0;
                data_oe_d   = 1'b0;
                state_d     = S_INHIBIT;
            end else begin
                error_c = 1'b1;
                err_new = fail_nack ? ERR_NACK : ERR_XFER;
            end
`else
            error_c = 1'b1;
            err_new = fail_nack ? ERR_NACK : ERR_XFER;
`endif
        end

        if (error_c) begin
            err_code_d = err_new;
            data_oe_d  = 1'b0;
            state_d    = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            inh_cnt_q  <= '0;
            to_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            data_oe_q  <= 1'b0;
            byte_q     <= '0;
            parity_q   <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            inh_cnt_q  <= inh_cnt_d;
            to_cnt_q   <= to_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            data_oe_q  <= data_oe_d;
            byte_q     <= byte_d;
            parity_q   <= parity_d;
            err_code_q <= err_code_d;
        end
    end

`ifdef PS2_TX_RETRY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retry_cnt_q <= '0;
        end else begin
            retry_cnt_q <= retry_cnt_d;
        end
    end
`endif

    // Line drives decode straight from state so an asynchronous reset releases them at once.
    always_comb begin
        ps2_data_oe = 1'b0;
        case (state_q)
            S_INHIBIT: ps2_data_oe = (inh_cnt_q == INH_LAST);
            S_REQ:     ps2_data_oe = 1'b1;
            S_DATA:    ps2_data_oe = data_oe_q;
            default:   ps2_data_oe = 1'b0;
        endcase
        if (error_c) begin
            ps2_data_oe = 1'b0;
        end
    end

    assign ps2_clk_oe = (state_q == S_INHIBIT);
    assign tx_ready   = (state_q == S_IDLE);
    assign rx_inhibit = (state_q != S_IDLE);
    assign tx_done    = done_c;
    assign tx_error   = error_c;
    assign err_code   = error_c ? err_new : err_code_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: device BFM on a wired-AND bus, frame/parity reference model,
// expected-response queue drained by a pulse monitor.
module tb_ps2_host_tx;
    localparam int INH      = 20;
    localparam int START_TO = 500;
    localparam int XFER_TO  = 2000;
    localparam int FLT      = 2;
    localparam int HALF     = 30;
`ifdef PS2_TX_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    // Clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       rx_inhibit, tx_done, tx_error;
    logic [1:0] err_code;
    logic [2:0] dbg_state;
    logic       dev_clk_low, dev_data_low;
    logic       ps2_clk_in, ps2_data_in;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES      (INH),
        .START_TIMEOUT_CYCLES(START_TO),
        .XFER_TIMEOUT_CYCLES (XFER_TO),
        .FILTER_LEN          (FLT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .rx_inhibit (rx_inhibit),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .err_code   (err_code),
        .dbg_state  (dbg_state)
    );

    int tests = 0;
    int fails = 0;
    logic [3:0] exp_q[$];
    logic [1:0] model_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: frame contents and transaction outcome.
    function automatic logic [9:0] model_frame(input logic [7:0] b);
        logic [9:0] f;
        int ones;
        int v;
        ones = 0;
        v = int'(b);
        for (int i = 0; i < 8; i++) begin
            f[i] = ((v >> i) % 2) == 1;
            ones += (v >> i) % 2;
        end
        f[8] = (ones % 2) == 0;
        f[9] = 1'b1;
        return f;
    endfunction

    // beh: 0 = never clocks, 1..10 = stops after that many edges, 11 = ACK, 12 = NACK
    function automatic void model_txn(input int beh[3], output int attempts, output logic [3:0] resp);
        logic [1:0] code;
        attempts = 0;
        resp = 4'b0000;
        for (int a = 0; a < 3; a++) begin
            attempts++;
            if (beh[a] == 11) begin
                resp = {2'b10, model_err};
                return;
            end
            code = (beh[a] == 0) ? 2'b10 : (beh[a] == 12) ? 2'b01 : 2'b11;
            if (code == 2'b10 || !RETRY || a == 2) begin
                model_err = code;
                resp = {2'b01, code};
                return;
            end
        end
    endfunction

    // Inhibit phase tracker: length of each clock-low phase and the REQ entry cycle.
    int inh_run = 0;
    int inh_phases = 0;
    int inh_min = 0;
    int inh_max = 0;
    int req_cycle = 0;
    always @(negedge clk) begin
        if (ps2_clk_oe) begin
            inh_run++;
        end else if (inh_run != 0) begin
            if (inh_run < inh_min) inh_min = inh_run;
            if (inh_run > inh_max) inh_max = inh_run;
            inh_phases++;
            req_cycle = cyc;
            inh_run = 0;
        end
    end

    // Scoreboard monitor
    int err_cycle = 0;
    bit chk_ready = 1'b0;
    always @(negedge clk) begin
        logic [3:0] exp_v;
        if (chk_ready) begin
            chk_ready = 1'b0;
            check("ready_after_pulse", {tx_ready, rx_inhibit}, 2'b10);
        end
        if (rst && (tx_done || tx_error)) begin
            err_cycle = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {tx_done, tx_error, err_code}, 4'b0000);
            end else begin
                exp_v = exp_q.pop_front();
                check("response", {tx_done, tx_error, err_code}, exp_v);
            end
            if (tx_error) check("error_lines_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
            chk_ready = 1'b1;
        end
    end

    // Driver tasks
    task automatic start_req(input logic [7:0] b);
        int w;
        w = 0;
        while (!tx_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!tx_ready) check("wait_ready", 0, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic bfm_attempt(input int beh, input int phase_target, output logic [9:0] got);
        int w;
        int n;
        got = '0;
        w = 0;
        while (!(inh_phases >= phase_target && ps2_data_in == 1'b0) && w < 5000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 5000) begin
            check("bfm_request_seen", 0, 1);
            return;
        end
        if (beh == 0) return;
        n = (beh >= 11) ? 11 : beh;
        repeat (10) @(negedge clk);
        for (int e = 1; e <= n; e++) begin
            if (e == 11 && beh == 11) dev_data_low = 1'b1;
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            if (e <= 10) got[e-1] = ps2_data_in;
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        dev_data_low = 1'b0;
    endtask

    task automatic run_txn(input logic [7:0] b, input int b0, input int b1, input int b2);
        int beh[3];
        int attempts;
        int base;
        int w;
        logic [3:0] resp;
        logic [9:0] got;
        beh[0] = b0;
        beh[1] = b1;
        beh[2] = b2;
        model_txn(beh, attempts, resp);
        exp_q.push_back(resp);
        base = inh_phases;
        inh_min = 1000000;
        inh_max = 0;
        start_req(b);
        repeat (2) @(negedge clk);
        tx_data  = ~b;
        tx_valid = 1'b1;
        @(negedge clk);
        check("busy_flags", {tx_ready, rx_inhibit}, 2'b01);
        repeat (2) @(negedge clk);
        tx_valid = 1'b0;
        for (int a = 0; a < attempts; a++) begin
            bfm_attempt(beh[a], base + a + 1, got);
            if (beh[a] >= 11) check("frame_bits", got, model_frame(b));
        end
        w = 0;
        while (exp_q.size() != 0 && w < 6000) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() != 0) begin
            check("response_timeout", 0, 1);
            exp_q.delete();
        end
        repeat (4) @(negedge clk);
        check("inhibit_phases", inh_phases - base, attempts);
        check("inhibit_len_min", inh_min, INH);
        check("inhibit_len_max", inh_max, INH);
        if (beh[attempts-1] == 0) check("start_timeout_cycles", err_cycle - req_cycle, START_TO);
    endtask

    task automatic reset_mid_data();
        logic [9:0] got;
        int base;
        base = inh_phases;
        start_req(8'hA5);
        bfm_attempt(4, base + 1, got);
        check("pre_reset_data_oe", {ps2_clk_oe, ps2_data_oe}, 2'b01);
        #2 rst = 1'b0;
        #1 check("reset_releases_lines", {ps2_clk_oe, ps2_data_oe, tx_done, tx_error}, 4'b0000);
        model_err = 2'b00;
        repeat (3) @(negedge clk);
        check("in_reset_state", {tx_ready, rx_inhibit, err_code}, 4'b1000);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        run_txn(8'h55, 11, 11, 11);
    endtask

    // Watchdog
    initial begin
        repeat (95000) @(posedge clk);
        fails++;
        $display("FAIL watchdog: got no finish, expected finish before cycle budget");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Main sequence
    initial begin
        int r;
        int bh[3];
        tx_data      = 8'h00;
        tx_valid     = 1'b0;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        model_err    = 2'b00;
        repeat (3) @(negedge clk);
        check("reset_state", {tx_ready, ps2_clk_oe, ps2_data_oe, rx_inhibit, tx_done, tx_error, err_code},
              8'b1000_0000);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        run_txn(8'hED, 11, 11, 11);
        run_txn(8'hFF, 11, 11, 11);
        run_txn(8'h00, 11, 11, 11);
        run_txn(8'h01, 11, 11, 11);
        run_txn(8'h3C, 12, 11, 11);
        run_txn(8'hF4, 0, 0, 0);
        run_txn(8'hF2, 5, 5, 5);
        reset_mid_data();
        run_txn(8'hAA, 12, 12, 11);
        run_txn(8'h96, 12, 12, 12);

        for (int t = 0; t < 12; t++) begin
            for (int a = 0; a < 3; a++) begin
                r = $urandom_range(0, 7);
                bh[a] = (r <= 5) ? 11 : (r == 6) ? 12 : $urandom_range(1, 10);
            end
            run_txn(8'($urandom_range(0, 255)), bh[0], bh[1], bh[2]);
        end

        check("leftover_expected", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
